// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: FSM states,
// default width and the iteration-counter width helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DZ   = 2'd3
  } div_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/cla_sub_n.sv
// N-bit subtractor computing a + ~b + 1 through chained 4-bit
// carry-lookahead groups; borrow_out is the inverted final carry.
module cla_sub_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  localparam int G = N / 4;

  logic [N-1:0] b_n;
  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [G:0]   c;

  assign b_n  = ~b;
  assign gen  = a & b_n;
  assign prop = a ^ b_n;
  assign c[0] = 1'b1;

  for (genvar gi = 0; gi < G; gi++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic [4:0] cc;

    assign gg    = gen[4*gi +: 4];
    assign pp    = prop[4*gi +: 4];
    assign cc[0] = c[gi];
    assign cc[1] = gg[0] | (pp[0] & cc[0]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cc[0]);
    assign cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & cc[0]);

    assign diff[4*gi +: 4] = pp ^ cc[3:0];
    assign c[gi+1]         = cc[4];
  end

  assign borrow_out = ~c[G];

endmodule

// File: rtl/seq_divider_32.sv
// Iterative signed restoring divider: quotient for LO, remainder for HI,
// one trial subtraction per cycle, start/done handshake for the control unit.
module seq_divider_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start (with operands) is taken only on an edge where the FSM
  // is IDLE; busy covers the operation; done is a one-cycle pulse, and the
  // result outputs hold until the next completion. start in the done cycle
  // is accepted at the following edge.

  localparam int CW = cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // R is stored as WIDTH bits: since R < D, its extra top bit only exists
  // for the cycle of the shift, where it is the MSB of shift_r.
  logic [WIDTH:0]   shift_r;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_borrow;
  logic             trial_ok;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;

  assign shift_r  = {r_q, q_q[WIDTH-1]};
  assign trial_ok = shift_r[WIDTH] | ~trial_borrow;

  assign dividend_abs = i_dividend[WIDTH-1] ? (~i_dividend + WIDTH'(1)) : i_dividend;
  assign divisor_abs  = i_divisor[WIDTH-1]  ? (~i_divisor + WIDTH'(1))  : i_divisor;

  cla_sub_n #(.N(WIDTH)) u_trial_sub (
    .a          (shift_r[WIDTH-1:0]),
    .b          (d_q),
    .diff       (trial_diff),
    .borrow_out (trial_borrow)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dz_d   = 1'b0;
          if (i_divisor == '0) begin
            // Q holds the raw dividend so DZ can return it as the remainder.
            q_d     = i_dividend;
            state_d = DZ;
          end else begin
            q_d       = dividend_abs;
            d_d       = divisor_abs;
            neg_quo_d = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            neg_rem_d = i_dividend[WIDTH-1];
            r_d       = '0;
            count_d   = '0;
            state_d   = ITER;
          end
        end
      end
      ITER: begin
        r_d     = trial_ok ? trial_diff : shift_r[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], trial_ok};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        quotient_d  = neg_quo_q ? (~q_q + WIDTH'(1)) : q_q;
        remainder_d = neg_rem_q ? (~r_q + WIDTH'(1)) : r_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      DZ: begin
        quotient_d  = '1;
        remainder_d = q_q;
        dz_d        = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32: an arithmetic reference model feeds an
// expected-result queue that a per-cycle compare process checks.
module tb_seq_divider_32;

  localparam int W       = 32;
  localparam int LAT     = W + 1;
  localparam int LAT_DZ  = 1;

  // clock / reset
  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] i_dividend = '0;
  logic [W-1:0] i_divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  seq_divider_32 dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference: signed division truncating toward zero, with the divider's
  // divide-by-zero and overflow conventions.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic         exp_dz_q[$];
  int           exp_e0_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dz = 1'b0;

  always @(negedge clk) begin
    logic busy_exp, dz_exp;
    busy_exp = 1'b0;
    dz_exp   = last_dz;
    if (exp_q.size() > 0) begin
      busy_exp = (edge_n >= exp_e0_q[0]) && (edge_n < exp_cyc_q[0]);
      if (edge_n >= exp_e0_q[0]) dz_exp = 1'b0;
    end
    chk("busy", W'(busy), W'(busy_exp));
    if (exp_q.size() > 0 && edge_n == exp_cyc_q[0]) begin
      chk("done_pulse", W'(done), W'(1));
      chk("quotient", quotient, exp_q[0]);
      chk("remainder", remainder, exp_r_q[0]);
      chk("div_by_zero", W'(div_by_zero), W'(exp_dz_q[0]));
      last_q  = exp_q.pop_front();
      last_r  = exp_r_q.pop_front();
      last_dz = exp_dz_q.pop_front();
      void'(exp_e0_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end else begin
      chk("no_done", W'(done), W'(0));
      chk("quotient_hold", quotient, last_q);
      chk("remainder_hold", remainder, last_r);
      chk("dz_hold", W'(div_by_zero), W'(dz_exp));
    end
  end

  // driver tasks (called at a negedge)
  int last_e0 = 0;

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         edz;
    model(a, b, eq, er, edz);
    start      = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    last_e0    = edge_n + 1;
    exp_q.push_back(eq);
    exp_r_q.push_back(er);
    exp_dz_q.push_back(edz);
    exp_e0_q.push_back(last_e0);
    exp_cyc_q.push_back(last_e0 + ((b == 0) ? LAT_DZ : LAT));
    @(negedge clk);
    start      = 1'b0;
    i_dividend = W'($urandom_range(0, 1000));
    i_divisor  = W'($urandom_range(0, 1000));
  endtask

  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end else begin
      chk("latency", W'(edge_n - last_e0), W'(exp_lat));
    end
  endtask

  task automatic run_lit(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lq, input logic [W-1:0] lr, input logic ldz);
    start_op(a, b);
    wait_done((b == 0) ? LAT_DZ : LAT);
    chk("lit_quotient", quotient, lq);
    chk("lit_remainder", remainder, lr);
    chk("lit_dz", W'(div_by_zero), W'(ldz));
  endtask

  logic [W-1:0] extra_a [4] = '{32'd0, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'd123456789};
  logic [W-1:0] extra_b [4] = '{32'd5, 32'd2, 32'h8000_0000, 32'hFFFF_FC18};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_quotient", quotient, '0);
    chk("reset_remainder", remainder, '0);
    chk("reset_flags", W'({busy, done, div_by_zero}), '0);
    clr_n = 1'b1;
    @(negedge clk);

    run_lit(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_lit(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_lit(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
    run_lit(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_lit(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run_lit(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_lit(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      start_op(extra_a[i], extra_b[i]);
      wait_done(LAT);
    end

    // start while busy is ignored; then start again in the done cycle
    start_op(32'd1000, 32'd3);
    while (edge_n < last_e0 + 9) @(negedge clk);
    start      = 1'b1;
    i_dividend = 32'd8;
    i_divisor  = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT);
    chk("ignored_quotient", quotient, 32'd333);
    chk("ignored_remainder", remainder, 32'd1);
    run_lit(32'd8, 32'd2, 32'd4, 32'd0, 1'b0);

    // reset mid-operation
    start_op(32'd1000, 32'd3);
    while (edge_n < last_e0 + 14) @(negedge clk);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    exp_q.delete();
    exp_r_q.delete();
    exp_dz_q.delete();
    exp_e0_q.delete();
    exp_cyc_q.delete();
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    #1;
    chk("midreset_quotient", quotient, '0);
    chk("midreset_remainder", remainder, '0);
    chk("midreset_flags", W'({busy, done, div_by_zero}), '0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    run_lit(32'd7, 32'd7, 32'd1, 32'd0, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
